// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the control/operand inputs and the result outputs of mem_access_unit.
//   master : the control side (control FSM / testbench) drives requests,
//            reads results.
//   slave  : the access unit itself.
// Handshake: the master raises Start while the unit is idle (Busy=0). The unit
// captures every operand and control bit on that edge, holds Busy high until it
// returns to idle, and pulses Done for one cycle when the results are valid.
// Start is ignored while Busy is high.
// dbg_state exposes the sequencer state for checkers.
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [1:0]       IorD;
  logic [1:0]       DataSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             Jump;
  logic [1:0]       Branch;
  logic             ShouldBranchIn;
  logic [WIDTH-1:0] ALUOutIn;
  logic [WIDTH-1:0] ImmIn;
  logic [WIDTH-1:0] SPIn;
  logic [WIDTH-1:0] RegAIn;
  logic [WIDTH-1:0] Inputio;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] IROut;
  logic [WIDTH-1:0] MDROut;
  logic [WIDTH-1:0] PCOut;
  logic             Overflow;
  logic [1:0]       dbg_state;

  modport master (
    output Start, IorD, DataSrc, MemRead, MemWrite, IRWrite, PCWrite, Jump,
           Branch, ShouldBranchIn, ALUOutIn, ImmIn, SPIn, RegAIn, Inputio,
    input  Busy, Done, IROut, MDROut, PCOut, Overflow, dbg_state
  );

  modport slave (
    input  Start, IorD, DataSrc, MemRead, MemWrite, IRWrite, PCWrite, Jump,
           Branch, ShouldBranchIn, ALUOutIn, ImmIn, SPIn, RegAIn, Inputio,
    output Busy, Done, IROut, MDROut, PCOut, Overflow, dbg_state
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Fetch/memory datapath: PC, IR, MDR and a word memory behind an address mux,
// driven by a multi-cycle access sequencer (IDLE -> ACCESS -> DONE -> IDLE).
// Ports:
//   CLK    : clock, all state on rising edge
//   Reset  : asynchronous, active-high
//   bus    : mem_access_unit_if.slave (operands, controls, Busy/Done, IR/MDR/PC,
//            Overflow, dbg_state)
// An access takes MEM_LAT cycles in ACCESS; the memory op and PC update happen
// on the edge that leaves ACCESS, and Done is high during the following cycle.
// MEM_LAT must be in 1..15 (4-bit wait counter).
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 10,
  parameter int MEM_LAT  = 2,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  mem_access_unit_if.slave  bus
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [3:0]      LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [WIDTH-1:0] PC_STEP_W = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] PC_RESET  = WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Sequencer controls derived from the state
  logic accept;    // Start seen in IDLE: capture everything this edge
  logic complete;  // last ACCESS cycle: perform op and PC update this edge

  // Latched request
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              ir_write_q, ir_write_d;
  logic              pc_write_q, pc_write_d;
  logic              jump_q, jump_d;
  logic [1:0]        branch_q, branch_d;
  logic              sb_q, sb_d;

  // Architectural registers
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  ir_q, ir_d;
  logic [WIDTH-1:0]  mdr_q, mdr_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rdata;
  logic              taken;
  logic [WIDTH-1:0]  pc_addend;
  logic [WIDTH:0]    pc_sum;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.Start)   state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept        = (state_q == S_IDLE) && bus.Start;
    complete      = (state_q == S_ACCESS) && (cnt_q == '0);
    bus.Busy      = (state_q == S_ACCESS) || (state_q == S_DONE);
    bus.Done      = (state_q == S_DONE);
    bus.dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Request capture and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    imm_d       = imm_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    ir_write_d  = ir_write_q;
    pc_write_d  = pc_write_q;
    jump_d      = jump_q;
    branch_d    = branch_q;
    sb_d        = sb_q;

    if (accept) begin
      cnt_d = LAT_INIT;
      // Byte address: bit 0 selects a byte within the word and is dropped.
      case (bus.IorD)
        2'd0:    idx_d = pc_q[ADDR_W:1];
        2'd1:    idx_d = bus.ALUOutIn[ADDR_W:1];
        2'd2:    idx_d = bus.SPIn[ADDR_W:1];
        default: idx_d = bus.ImmIn[ADDR_W:1];
      endcase
      case (bus.DataSrc)
        2'd0:    wdata_d = bus.RegAIn;
        2'd1:    wdata_d = bus.Inputio;
        2'd2:    wdata_d = bus.ALUOutIn;
        default: wdata_d = bus.ImmIn;
      endcase
      imm_d       = bus.ImmIn;
      mem_read_d  = bus.MemRead;
      mem_write_d = bus.MemWrite;
      ir_write_d  = bus.IRWrite;
      pc_write_d  = bus.PCWrite;
      jump_d      = bus.Jump;
      branch_d    = bus.Branch;
      sb_d        = bus.ShouldBranchIn;
    end else if ((state_q == S_ACCESS) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: memory read results and PC update. The PC cannot change while
  // a request is pending, so pc_q is the PC captured at Start.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata     = mem[idx_q];
    taken     = ((branch_q == 2'd1) && sb_q) || ((branch_q == 2'd2) && !sb_q);
    pc_addend = taken ? imm_q : PC_STEP_W;
    pc_sum    = {1'b0, pc_q} + {1'b0, pc_addend};

    pc_d  = pc_q;
    ovf_d = ovf_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;

    if (complete) begin
      // A write takes priority; MDR/IR only load on a pure read.
      if (!mem_write_q && mem_read_q) begin
        mdr_d = rdata;
        if (ir_write_q) ir_d = rdata;
      end
      if (pc_write_q) begin
        if (jump_q) begin
          pc_d  = imm_q;
          ovf_d = 1'b0;
        end else begin
          pc_d  = pc_sum[WIDTH-1:0];
          ovf_d = pc_sum[WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      imm_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      jump_q      <= 1'b0;
      branch_q    <= 2'd0;
      sb_q        <= 1'b0;
      pc_q        <= PC_RESET;
      ir_q        <= '0;
      mdr_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      imm_q       <= imm_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ir_write_q  <= ir_write_d;
      pc_write_q  <= pc_write_d;
      jump_q      <= jump_d;
      branch_q    <= branch_d;
      sb_q        <= sb_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Memory contents survive reset. Reset forces IDLE asynchronously, which
  // drops 'complete' and so cancels any pending write.
  always_ff @(posedge CLK) begin
    if (complete && mem_write_q) mem[idx_q] <= wdata_q;
  end

  assign bus.PCOut    = pc_q;
  assign bus.IROut    = ir_q;
  assign bus.MDROut   = mdr_q;
  assign bus.Overflow = ovf_q;

endmodule
